fetch_stage: RTL and testbench

//   IF stage and IF/ID pipeline register feeding the decode-stage branch/jump resolver.

---
 rtl/fetch_stage.sv | 107 ++++++++++
 tb/tb_fetch_stage.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// Purpose : IF stage plus IF/ID register. Holds the PC, fetches from a combinational
//           instruction memory, and redirects/squashes on a taken branch/jump resolved in decode.
// Latency : a fetch accepted at edge N is in D after edge N; a taken branch/jump costs one bubble.
// Backpr. : stall_FD freezes the PC and IF/ID. imem_rvalid=0 holds the PC and inserts a bubble.
// Ports   : clk/rst_n (async active-low); stall_FD, realBJ_D, targetPC_D from hazard/decode;
//           imem_addr/imem_rdata/imem_rvalid to instruction memory; pc_F, pc_D, instr_D, valid_D
//           to decode; fetch_cnt/flush_cnt are free-running 32-bit event counters.
module fetch_stage #(
  parameter int unsigned      width    = 32,
  parameter logic [width-1:0] RESET_PC = '0,
  parameter logic [width-1:0] NOP      = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             stall_FD,
  input  logic             realBJ_D,
  input  logic [width-1:0] targetPC_D,
  input  logic [width-1:0] imem_rdata,
  input  logic             imem_rvalid,
  output logic [width-1:0] imem_addr,
  output logic [width-1:0] pc_F,
  output logic [width-1:0] pc_D,
  output logic [width-1:0] instr_D,
  output logic             valid_D,
  output logic [31:0]      fetch_cnt,
  output logic [31:0]      flush_cnt
);

  logic [width-1:0] pc_q, pc_d;
  logic [width-1:0] pcd_q, pcd_d;
  logic [width-1:0] instr_q, instr_d;
  logic             vld_q, vld_d;
  logic [31:0]      fetch_cnt_q, fetch_cnt_d;
  logic [31:0]      flush_cnt_q, flush_cnt_d;
  logic             redirect;

  // A branch seen while stalled still has unresolved operands, so it must not redirect.
  assign redirect = realBJ_D & ~stall_FD;

  // Target low bits are discarded: fetch is always word-aligned.
  logic unused_tgt_lsb;
  assign unused_tgt_lsb = ^targetPC_D[1:0];

  always_comb begin
    pc_d = pc_q;
    if (redirect) begin
      pc_d = {targetPC_D[width-1:2], 2'b00};
    end else if (stall_FD || !imem_rvalid) begin
      pc_d = pc_q;
    end else begin
      pc_d = pc_q + width'(4);
    end
  end

  always_comb begin
    pcd_d       = pcd_q;
    instr_d     = instr_q;
    vld_d       = vld_q;
    fetch_cnt_d = fetch_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (stall_FD) begin
      // hold everything
    end else if (redirect) begin
      // Squash the wrong-path instruction currently being fetched.
      pcd_d       = pc_q;
      instr_d     = NOP;
      vld_d       = 1'b0;
      flush_cnt_d = flush_cnt_q + 32'd1;
    end else if (!imem_rvalid) begin
      pcd_d   = pc_q;
      instr_d = NOP;
      vld_d   = 1'b0;
    end else begin
      pcd_d       = pc_q;
      instr_d     = imem_rdata;
      vld_d       = 1'b1;
      fetch_cnt_d = fetch_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q        <= RESET_PC;
      pcd_q       <= '0;
      instr_q     <= NOP;
      vld_q       <= 1'b0;
      fetch_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      pc_q        <= pc_d;
      pcd_q       <= pcd_d;
      instr_q     <= instr_d;
      vld_q       <= vld_d;
      fetch_cnt_q <= fetch_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign imem_addr = {pc_q[width-1:2], 2'b00};
  assign pc_F      = pc_q;
  assign pc_D      = pcd_q;
  assign instr_D   = instr_q;
  assign valid_D   = vld_q;
  assign fetch_cnt = fetch_cnt_q;
  assign flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Purpose : directed bench for fetch_stage with a scoreboard queue of expected snapshots.
// Latency : expected state is queued 1 time unit after each rising edge, checked on the next falling edge.
// Backpr. : n/a (bench).
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall_FD, realBJ_D, imem_rvalid;
  logic [31:0] targetPC_D, imem_rdata, imem_addr;
  logic [31:0] pc_F, pc_D, instr_D, fetch_cnt, flush_cnt;
  logic        valid_D;

  always #5 clk = ~clk;

  // Instruction memory model: each word's contents are its address XOR 0xDEAD0000.
  assign imem_rdata = imem_addr ^ 32'hDEAD_0000;

  fetch_stage #(.width(32), .RESET_PC(32'h0), .NOP(32'h0)) dut (
    .clk(clk), .rst_n(rst_n), .stall_FD(stall_FD), .realBJ_D(realBJ_D),
    .targetPC_D(targetPC_D), .imem_rdata(imem_rdata), .imem_rvalid(imem_rvalid),
    .imem_addr(imem_addr), .pc_F(pc_F), .pc_D(pc_D), .instr_D(instr_D),
    .valid_D(valid_D), .fetch_cnt(fetch_cnt), .flush_cnt(flush_cnt)
  );

  typedef struct {
    string       name;
    logic [31:0] pcf, pcd, ins;
    logic        vld;
    logic [31:0] fc, flc;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;
  bit   done     = 1'b0;

  task automatic chk(input string nm, input string fld, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s.%s actual=%h required=%h", nm, fld, act, exp);
    end
  endtask

  // Monitor: whenever an expected snapshot is pending, compare the DUT outputs against it.
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      chk(e.name, "pc_F",      pc_F,             e.pcf);
      chk(e.name, "imem_addr", imem_addr,        e.pcf);
      chk(e.name, "pc_D",      pc_D,             e.pcd);
      chk(e.name, "instr_D",   instr_D,          e.ins);
      chk(e.name, "valid_D",   {31'd0, valid_D}, {31'd0, e.vld});
      chk(e.name, "fetch_cnt", fetch_cnt,        e.fc);
      chk(e.name, "flush_cnt", flush_cnt,        e.flc);
    end
  end

  task automatic push(input string nm, input logic [31:0] pcf, input logic [31:0] pcd,
                      input logic [31:0] ins, input logic vld, input logic [31:0] fc,
                      input logic [31:0] flc);
    exp_t e;
    e.name = nm; e.pcf = pcf; e.pcd = pcd; e.ins = ins; e.vld = vld; e.fc = fc; e.flc = flc;
    sb.push_back(e);
  endtask

  // One directed vector: drive inputs away from the edge, clock once, queue the expected state.
  task automatic step(input string nm, input logic st, input logic bj, input logic [31:0] tgt,
                      input logic rv, input logic [31:0] pcf, input logic [31:0] pcd,
                      input logic [31:0] ins, input logic vld, input logic [31:0] fc,
                      input logic [31:0] flc);
    @(negedge clk);
    stall_FD = st; realBJ_D = bj; targetPC_D = tgt; imem_rvalid = rv;
    @(posedge clk);
    #1;
    push(nm, pcf, pcd, ins, vld, fc, flc);
  endtask

  initial begin
    #100000;
    if (!done) begin
      $display("FAIL watchdog actual=timeout required=finish");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
      $fatal(1, "watchdog");
    end
  end

  initial begin
    rst_n = 1'b0; stall_FD = 1'b0; realBJ_D = 1'b0; targetPC_D = '0; imem_rvalid = 1'b0;
    @(posedge clk);
    #1;
    push("reset", 32'h0, 32'h0, 32'h0, 1'b0, 32'd0, 32'd0);
    @(negedge clk);
    #2 rst_n = 1'b1;

    //   name          st  bj  target         rv  pc_F          pc_D          instr_D       v   fc  flc
    // Sequential fetch
    step("seq0",       0,  0,  32'h0,         1,  32'h4,        32'h0,        32'hDEAD0000, 1,  1,  0);
    step("seq1",       0,  0,  32'h0,         1,  32'h8,        32'h4,        32'hDEAD0004, 1,  2,  0);
    step("seq2",       0,  0,  32'h0,         1,  32'hC,        32'h8,        32'hDEAD0008, 1,  3,  0);
    step("seq3",       0,  0,  32'h0,         1,  32'h10,       32'hC,        32'hDEAD000C, 1,  4,  0);
    // Taken branch at 0x10 -> 0x40, one bubble
    step("bj40",       0,  1,  32'h40,        1,  32'h40,       32'h10,       32'h0,        0,  4,  1);
    step("bj40_nxt",   0,  0,  32'h0,         1,  32'h44,       32'h40,       32'hDEAD0040, 1,  5,  1);
    // Stall with a pending branch: everything frozen, then redirect on release
    step("stall0",     1,  1,  32'h80,        1,  32'h44,       32'h40,       32'hDEAD0040, 1,  5,  1);
    step("stall1",     1,  1,  32'h80,        1,  32'h44,       32'h40,       32'hDEAD0040, 1,  5,  1);
    step("stall2",     1,  1,  32'h80,        1,  32'h44,       32'h40,       32'hDEAD0040, 1,  5,  1);
    step("stall_rel",  0,  1,  32'h80,        1,  32'h80,       32'h44,       32'h0,        0,  5,  2);
    step("post_rel",   0,  0,  32'h0,         1,  32'h84,       32'h80,       32'hDEAD0080, 1,  6,  2);
    // Memory not ready at 0x8
    step("bj8",        0,  1,  32'h8,         1,  32'h8,        32'h84,       32'h0,        0,  6,  3);
    step("norv0",      0,  0,  32'h0,         0,  32'h8,        32'h8,        32'h0,        0,  6,  3);
    step("norv1",      0,  0,  32'h0,         0,  32'h8,        32'h8,        32'h0,        0,  6,  3);
    step("rv_back",    0,  0,  32'h0,         1,  32'hC,        32'h8,        32'hDEAD0008, 1,  7,  3);
    // Misaligned targets are forced to a word boundary; PC wraps at the top
    step("bj43",       0,  1,  32'h43,        1,  32'h40,       32'hC,        32'h0,        0,  7,  4);
    step("bj_top",     0,  1,  32'hFFFFFFFE,  1,  32'hFFFFFFFC, 32'h40,       32'h0,        0,  7,  5);
    step("wrap",       0,  0,  32'h0,         1,  32'h0,        32'hFFFFFFFC, 32'h2152FFFC, 1,  8,  5);
    // Redirect while memory is not ready still redirects and counts a flush
    step("bj_norv",    0,  1,  32'h20,        0,  32'h20,       32'h0,        32'h0,        0,  8,  6);
    step("after",      0,  0,  32'h0,         1,  32'h24,       32'h20,       32'hDEAD0020, 1,  9,  6);

    // Asynchronous reset pulse between clock edges
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1 push("async_rst", 32'h0, 32'h0, 32'h0, 1'b0, 32'd0, 32'd0);
    @(negedge clk);
    imem_rvalid = 1'b0;
    #2 rst_n = 1'b1;
    step("rst_fetch",  0,  0,  32'h0,         1,  32'h4,        32'h0,        32'hDEAD0000, 1,  1,  0);

    @(negedge clk);
    @(negedge clk);
    #1;
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain actual=%0d required=0", sb.size());
    end
    done = 1'b1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
